pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_stage_cell.sv | 47 ++++
 rtl/pipe_stage_reg.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipe_stage_reg slice.
//
// Holds the legal DEPTH range, the default payload widths, the stage record
// {valid, ctrl, data} at those default widths, and the saturating step used
// by the occupancy counter.
package pipe_pkg;

  localparam int PIPE_DEPTH_MIN = 1;
  localparam int PIPE_DEPTH_MAX = 4;

  localparam int PIPE_CTRL_W = 4;
  localparam int PIPE_DATA_W = 32;

  // One stage's contents at the default widths. Parameterised instances use
  // a local record with the same field order.
  typedef struct packed {
    logic                   valid;
    logic [PIPE_CTRL_W-1:0] ctrl;
    logic [PIPE_DATA_W-1:0] data;
  } stage_t;

  // +1 / -1 / 0 step that never wraps below zero or above max_occ.
  function automatic int unsigned occ_step(input int unsigned occ,
                                           input logic        inc,
                                           input logic        dec,
                                           input int unsigned max_occ);
    if (inc && !dec) return (occ >= max_occ) ? max_occ : occ + 1;
    if (dec && !inc) return (occ == 0) ? 0 : occ - 1;
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// pipe_stage_cell -- one register stage of pipe_stage_reg.
//
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   kill             : drop the held entry (valid and masked ctrl bits cleared,
//                      data kept); wins over load
//   load             : take d_* this edge, otherwise hold
//   d_valid/ctrl/data: incoming record
//   q_valid/ctrl/data: held record
//
// Invariant kept here: whenever q_valid is 0 the CTRL_MASK bits of q_ctrl are
// 0, so a bubble never carries live control downstream.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int                CTRL_W    = PIPE_CTRL_W,
  parameter int                DATA_W    = PIPE_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_MASK = '1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              kill,
  input  logic              load,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
    end else if (kill) begin
      q_valid <= 1'b0;
      q_ctrl  <= q_ctrl & ~CTRL_MASK;
    end else if (load) begin
      q_valid <= d_valid;
      q_ctrl  <= d_valid ? d_ctrl : (d_ctrl & ~CTRL_MASK);
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- DEPTH-stage pipeline register with stall, flush and kill.
//
// Parameters:
//   DATA_W    : payload width, never masked
//   CTRL_W    : control field width
//   CTRL_MASK : control bits forced to 0 on any bubble (stall, flush, kill)
//   DEPTH     : number of register stages, 1..4
//
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   in_stall/in_flush : upstream has no live entry this cycle
//   out_stall         : downstream stalled, every stage holds
//   kill              : invalidate every in-flight entry (beats out_stall)
//   in_ctrl/in_data   : upstream record
//   in_ready          : the record on in_* is accepted this cycle
//   out_ctrl/out_data/out_valid : last stage
//   occupancy         : number of live entries held (stages + skid)
//
// Build option: define PIPE_STAGE_SKID_EN to add one skid entry that catches
// a live input arriving while out_stall is high; in_ready then follows the
// skid entry instead of out_stall.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                CTRL_W    = 4,
  parameter logic [CTRL_W-1:0] CTRL_MASK = {CTRL_W{1'b1}},
  parameter int                DEPTH     = 1,
  localparam int               OCC_W     = $clog2(DEPTH + 2)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_stall,
  input  logic              in_flush,
  input  logic              out_stall,
  input  logic              kill,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [OCC_W-1:0]  occupancy
);

  logic                          in_valid;
  logic                          adv;
  logic                          ready_int;
  logic                          s0_valid;
  logic [CTRL_W-1:0]             s0_ctrl;
  logic [DATA_W-1:0]             s0_data;
  logic                          occ_inc;
  logic                          occ_dec;
  logic [OCC_W-1:0]              occ_q;

  logic [DEPTH-1:0]              vld_pipe;
  logic [DEPTH-1:0][CTRL_W-1:0]  ctrl_pipe;
  logic [DEPTH-1:0][DATA_W-1:0]  data_pipe;

  assign in_valid = ~in_stall & ~in_flush;
  assign adv      = ~out_stall;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_cap;

  // Only an empty skid can catch; once full, in_ready drops and upstream holds.
  assign skid_cap = out_stall & ~skid_valid & in_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (kill) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= skid_ctrl & ~CTRL_MASK;
    end else if (skid_cap) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end else if (adv && skid_valid) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= skid_ctrl & ~CTRL_MASK;
    end
  end

  // A parked entry goes first; in_ready is low that cycle so the input
  // cannot also load.
  assign s0_valid  = skid_valid | in_valid;
  assign s0_ctrl   = skid_valid ? skid_ctrl : in_ctrl;
  assign s0_data   = skid_valid ? skid_data : in_data;
  assign ready_int = ~skid_valid;
  // skid -> stage 0 is a move, not a new entry, so it does not count.
  assign occ_inc   = skid_cap | (adv & ~skid_valid & in_valid);
`else
  // Without skid storage a live input during out_stall is dropped; upstream
  // is stalled along with us and presents it again.
  assign s0_valid  = in_valid;
  assign s0_ctrl   = in_ctrl;
  assign s0_data   = in_data;
  assign ready_int = ~out_stall;
  assign occ_inc   = adv & in_valid;
`endif

  assign occ_dec = adv & vld_pipe[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              d_valid;
    logic [CTRL_W-1:0] d_ctrl;
    logic [DATA_W-1:0] d_data;

    if (i == 0) begin : g_head
      assign d_valid = s0_valid;
      assign d_ctrl  = s0_ctrl;
      assign d_data  = s0_data;
    end else begin : g_body
      assign d_valid = vld_pipe[i-1];
      assign d_ctrl  = ctrl_pipe[i-1];
      assign d_data  = data_pipe[i-1];
    end

    pipe_stage_cell #(
      .CTRL_W    (CTRL_W),
      .DATA_W    (DATA_W),
      .CTRL_MASK (CTRL_MASK)
    ) u_cell (
      .clock   (clock),
      .reset   (reset),
      .kill    (kill),
      .load    (adv),
      .d_valid (d_valid),
      .d_ctrl  (d_ctrl),
      .d_data  (d_data),
      .q_valid (vld_pipe[i]),
      .q_ctrl  (ctrl_pipe[i]),
      .q_data  (data_pipe[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset || kill) begin
      occ_q <= '0;
    end else begin
      occ_q <= OCC_W'(occ_step(32'(occ_q), occ_inc, occ_dec, 32'(DEPTH + 1)));
    end
  end

  // Outputs read as zero for the whole reset window, including the cycle
  // before the first reset edge has cleared the registers.
  assign in_ready  = ~reset & ready_int;
  assign out_valid = ~reset & vld_pipe[DEPTH-1];
  assign out_ctrl  = reset ? '0 : ctrl_pipe[DEPTH-1];
  assign out_data  = reset ? '0 : data_pipe[DEPTH-1];
  assign occupancy = reset ? '0 : occ_q;

endmodule
